// File: rtl/kmeans_pkg.sv
// rtl/kmeans_pkg.sv - shared constants and types for the k-means convergence check
package kmeans_pkg;

    localparam int CENT_NUM  = 8;
    localparam int COORD_W   = 13;
    localparam int COORD_NUM = 7;
    localparam int DATA_W    = COORD_NUM * COORD_W;
    localparam int IDX_W     = $clog2(CENT_NUM);

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [DATA_W-1:0]  cent_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } conv_state_e;

endpackage

// File: rtl/coord_diff_cmp.sv
// rtl/coord_diff_cmp.sv - per-coordinate |new-old| <= threshold, ANDed over the centroid
module coord_diff_cmp
    import kmeans_pkg::*;
(
    input  cent_t  old_centroid,
    input  cent_t  new_centroid,
    input  coord_t threshold,
    output logic   all_ok
);

    logic [COORD_W:0] diff;
    logic [COORD_W:0] mag;

    // One extra bit holds the sign of the unsigned difference; negate when it is set.
    always_comb begin
        all_ok = 1'b1;
        diff   = '0;
        mag    = '0;
        for (int i = 0; i < COORD_NUM; i++) begin
            diff   = {1'b0, new_centroid[i*COORD_W +: COORD_W]}
                   - {1'b0, old_centroid[i*COORD_W +: COORD_W]};
            mag    = diff[COORD_W] ? (~diff + 1'b1) : diff;
            all_ok = all_ok & (mag <= {1'b0, threshold});
        end
    end

endmodule

// File: rtl/convergence_check_block.sv
// rtl/convergence_check_block.sv - centroid register file and per-iteration convergence check
module convergence_check_block
    import kmeans_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       cent_valid,
    input  logic [IDX_W-1:0]           cent_idx,
    input  logic                       divide_by_0,
    input  logic [DATA_W-1:0]          new_centroid,
    input  logic [COORD_W-1:0]         threshold,
    input  logic                       init_we,
    input  logic [IDX_W-1:0]           init_idx,
    input  logic [DATA_W-1:0]          init_centroid,
    output logic [CENT_NUM*DATA_W-1:0] centroids,
    output logic                       busy,
    output logic                       done,
    output logic                       converged
);

    conv_state_e                       state_q, state_d;
    logic [CENT_NUM-1:0]               seen_q, seen_d;
    logic [CENT_NUM-1:0]               ok_q, ok_d;
    logic [CENT_NUM-1:0][DATA_W-1:0]   cent_q, cent_d;
    logic                              done_q, done_d;
    logic                              conv_q, conv_d;

    logic                              all_ok;
    logic                              beat_ok;
    logic [CENT_NUM-1:0]               idx_oh;
    logic [CENT_NUM-1:0]               seen_new;
    logic [CENT_NUM-1:0]               ok_new;

    coord_diff_cmp u_cmp (
        .old_centroid (cent_q[cent_idx]),
        .new_centroid (new_centroid),
        .threshold    (threshold),
        .all_ok       (all_ok)
    );

    // Masks as they would stand after the current beat; an empty cluster always counts as converged.
    always_comb begin
        idx_oh   = CENT_NUM'(1) << cent_idx;
        beat_ok  = divide_by_0 | all_ok;
        seen_new = seen_q | idx_oh;
        ok_new   = (ok_q & ~idx_oh) | (beat_ok ? idx_oh : '0);
    end

    // Next-state: FSM, masks, register file writes and the completion pulse.
    always_comb begin
        state_d = state_q;
        seen_d  = seen_q;
        ok_d    = ok_q;
        cent_d  = cent_q;
        done_d  = 1'b0;
        conv_d  = conv_q;
        unique case (state_q)
            IDLE: begin
                if (init_we) begin
                    cent_d[init_idx] = init_centroid;
                end
                if (start) begin
                    state_d = ACTIVE;
                    seen_d  = '0;
                    ok_d    = '0;
                    conv_d  = 1'b0;
                end
            end
            ACTIVE: begin
                if (start) begin
                    seen_d = '0;
                    ok_d   = '0;
                    conv_d = 1'b0;
                end else if (cent_valid) begin
                    if (!divide_by_0) begin
                        cent_d[cent_idx] = new_centroid;
                    end
                    seen_d = seen_new;
                    ok_d   = ok_new;
                    if (&seen_new) begin
                        done_d  = 1'b1;
                        conv_d  = &ok_new;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            seen_q  <= '0;
            ok_q    <= '0;
            cent_q  <= '0;
            done_q  <= 1'b0;
            conv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seen_q  <= seen_d;
            ok_q    <= ok_d;
            cent_q  <= cent_d;
            done_q  <= done_d;
            conv_q  <= conv_d;
        end
    end

    assign centroids = cent_q;
    assign busy      = (state_q == ACTIVE);
    assign done      = done_q;
    assign converged = conv_q;

endmodule

// File: tb/tb_convergence_check_block.sv
// tb/tb_convergence_check_block.sv - directed self-checking bench for convergence_check_block
module tb_convergence_check_block;
    import kmeans_pkg::*;

    localparam int FLAT_W = CENT_NUM * DATA_W;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic                  cent_valid;
    logic [IDX_W-1:0]      cent_idx;
    logic                  divide_by_0;
    logic [DATA_W-1:0]     new_centroid;
    logic [COORD_W-1:0]    threshold;
    logic                  init_we;
    logic [IDX_W-1:0]      init_idx;
    logic [DATA_W-1:0]     init_centroid;
    logic [FLAT_W-1:0]     centroids;
    logic                  busy;
    logic                  done;
    logic                  converged;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] exp_cent [CENT_NUM];

    convergence_check_block dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .cent_valid    (cent_valid),
        .cent_idx      (cent_idx),
        .divide_by_0   (divide_by_0),
        .new_centroid  (new_centroid),
        .threshold     (threshold),
        .init_we       (init_we),
        .init_idx      (init_idx),
        .init_centroid (init_centroid),
        .centroids     (centroids),
        .busy          (busy),
        .done          (done),
        .converged     (converged)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] fill(input int v);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < COORD_NUM; i++) r[i*COORD_W +: COORD_W] = COORD_W'(v);
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] shift_all(input logic [DATA_W-1:0] c, input int d);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < COORD_NUM; i++) r[i*COORD_W +: COORD_W] = COORD_W'(int'(c[i*COORD_W +: COORD_W]) + d);
        return r;
    endfunction

    function automatic logic [FLAT_W-1:0] exp_flat();
        logic [FLAT_W-1:0] r;
        for (int n = 0; n < CENT_NUM; n++) r[n*DATA_W +: DATA_W] = exp_cent[n];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [FLAT_W-1:0] obs, input logic [FLAT_W-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int idx, input logic div0, input logic [DATA_W-1:0] v, input logic accepted);
        cent_valid   = 1'b1;
        cent_idx     = IDX_W'(idx);
        divide_by_0  = div0;
        new_centroid = v;
        tick();
        cent_valid   = 1'b0;
        divide_by_0  = 1'b0;
        if (accepted && !div0) exp_cent[idx] = v;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] v;
        rst_n = 1'b0; start = 1'b0; cent_valid = 1'b0; cent_idx = '0; divide_by_0 = 1'b0;
        new_centroid = '0; threshold = '0; init_we = 1'b0; init_idx = '0; init_centroid = '0;
        for (int n = 0; n < CENT_NUM; n++) exp_cent[n] = '0;
        tick();
        chk("reset_centroids", centroids, '0);
        chk("reset_done", FLAT_W'(done), '0);
        chk("reset_busy", FLAT_W'(busy), '0);
        chk("reset_conv", FLAT_W'(converged), '0);
        rst_n = 1'b1;
        tick();

        // cent_valid in IDLE must be ignored
        beat(0, 1'b0, fill(55), 1'b0);
        chk("idle_beat_ignored", centroids, exp_flat());
        chk("idle_beat_no_done", FLAT_W'(done), '0);

        // Initial load: value n in every coord
        for (int n = 0; n < CENT_NUM; n++) begin
            init_we = 1'b1; init_idx = IDX_W'(n); init_centroid = fill(n);
            tick();
            exp_cent[n] = fill(n);
        end
        init_we = 1'b0;
        chk("init_load", centroids, exp_flat());

        // Iteration 1: every coord old+2, threshold 2 (inclusive boundary)
        threshold = 13'd2;
        pulse_start();
        chk("it1_busy", FLAT_W'(busy), 1);
        for (int n = 0; n < CENT_NUM; n++) begin
            beat(n, 1'b0, shift_all(exp_cent[n], 2), 1'b1);
            if (n < CENT_NUM - 1) chk($sformatf("it1_nodone_%0d", n), FLAT_W'(done), '0);
        end
        chk("it1_done", FLAT_W'(done), 1);
        chk("it1_conv", FLAT_W'(converged), 1);
        chk("it1_idle", FLAT_W'(busy), '0);
        chk("it1_entries", centroids, exp_flat());
        tick();
        chk("it1_done_pulse", FLAT_W'(done), '0);
        chk("it1_conv_held", FLAT_W'(converged), 1);

        // Iteration 2: idx5 coord3 is old+3, one over threshold
        pulse_start();
        chk("it2_start_clears_conv", FLAT_W'(converged), '0);
        for (int n = 0; n < CENT_NUM; n++) begin
            v = shift_all(exp_cent[n], 2);
            if (n == 5) v[3*COORD_W +: COORD_W] = exp_cent[5][3*COORD_W +: COORD_W] + 13'd3;
            beat(n, 1'b0, v, 1'b1);
        end
        chk("it2_done", FLAT_W'(done), 1);
        chk("it2_conv", FLAT_W'(converged), '0);
        chk("it2_entries", centroids, exp_flat());

        // Iteration 3: coords move down by 2, idx2 is an empty cluster with all-ones data
        pulse_start();
        for (int n = 0; n < CENT_NUM; n++) begin
            if (n == 2) beat(n, 1'b1, '1, 1'b1);
            else        beat(n, 1'b0, shift_all(exp_cent[n], -2), 1'b1);
        end
        chk("it3_done", FLAT_W'(done), 1);
        chk("it3_conv", FLAT_W'(converged), 1);
        chk("it3_entry2_kept", centroids, exp_flat());

        // Iteration 4: out of order with a duplicate idx3; threshold 1
        threshold = 13'd1;
        pulse_start();
        beat(7, 1'b0, exp_cent[7], 1'b1);
        beat(0, 1'b0, exp_cent[0], 1'b1);
        beat(3, 1'b0, shift_all(exp_cent[3], 100), 1'b1);
        beat(3, 1'b0, shift_all(exp_cent[3], 1), 1'b1);
        beat(1, 1'b0, exp_cent[1], 1'b1);
        beat(2, 1'b0, exp_cent[2], 1'b1);
        beat(4, 1'b0, exp_cent[4], 1'b1);
        chk("ooo_nodone_after4", FLAT_W'(done), '0);
        beat(5, 1'b0, exp_cent[5], 1'b1);
        chk("ooo_nodone_after5", FLAT_W'(done), '0);
        chk("ooo_still_busy", FLAT_W'(busy), 1);
        beat(6, 1'b0, exp_cent[6], 1'b1);
        chk("ooo_done", FLAT_W'(done), 1);
        chk("ooo_conv_dup_overwrites_ok", FLAT_W'(converged), 1);
        chk("ooo_entry3_second", centroids, exp_flat());

        // Restart after 4 beats; init_we in ACTIVE ignored
        threshold = 13'd5;
        pulse_start();
        for (int n = 0; n < 4; n++) beat(n, 1'b0, shift_all(exp_cent[n], 1), 1'b1);
        init_we = 1'b1; init_idx = 3'd6; init_centroid = fill(77);
        tick();
        init_we = 1'b0;
        chk("active_init_ignored", centroids, exp_flat());
        pulse_start();
        chk("restart_busy", FLAT_W'(busy), 1);
        for (int n = 4; n < CENT_NUM; n++) beat(n, 1'b0, shift_all(exp_cent[n], 1), 1'b1);
        chk("restart_no_done", FLAT_W'(done), '0);
        chk("restart_still_busy", FLAT_W'(busy), 1);
        beat(0, 1'b0, shift_all(exp_cent[0], 1), 1'b1);
        beat(1, 1'b0, shift_all(exp_cent[1], 1), 1'b1);
        chk("restart_entries", centroids, exp_flat());

        // Reset after 6 beats of the restarted iteration
        #2;
        rst_n = 1'b0;
        #1;
        for (int n = 0; n < CENT_NUM; n++) exp_cent[n] = '0;
        chk("midrst_centroids", centroids, '0);
        chk("midrst_busy", FLAT_W'(busy), '0);
        chk("midrst_done", FLAT_W'(done), '0);
        chk("midrst_conv", FLAT_W'(converged), '0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("postrst_no_done", FLAT_W'(done), '0);
        chk("postrst_idle", FLAT_W'(busy), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
